// File: rtl/serv_rf_pkg.sv
// rtl/serv_rf_pkg.sv - shared state encoding and transfer lengths for the RF word port
package serv_rf_pkg;

    // Command sequencing: wait for grant, stream 32 bits, let the RF drain.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_XFER  = 2'd2,
        ST_RECOV = 2'd3
    } state_e;

    localparam int XFER_LEN  = 32;
    localparam int RECOV_LEN = 3;

    localparam logic [4:0] XFER_LAST  = 5'(XFER_LEN - 1);
    localparam logic [1:0] RECOV_LAST = 2'(RECOV_LEN - 1);

endpackage

// File: rtl/serv_rf_ser32.sv
// rtl/serv_rf_ser32.sv - 32-bit shift register: parallel load, LSB-first serial out, MSB serial in
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_load        load i_pdata (takes priority over shift)
//   i_pdata       parallel load word
//   i_shift       shift right one place, i_sdata enters at bit 31
//   i_sdata       serial input bit
//   o_sdata       serial output bit (current bit 0)
//   o_pnext       register contents after this cycle's load/shift
module serv_rf_ser32 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_pdata,
    input  logic        i_shift,
    input  logic        i_sdata,
    output logic        o_sdata,
    output logic [31:0] o_pnext
);

    logic [31:0] sr_q;
    logic [31:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (i_load) begin
            sr_d = i_pdata;
        end else if (i_shift) begin
            sr_d = {i_sdata, sr_q[31:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_sdata = sr_q[0];
    // Exposing the next value lets the owner capture a fully assembled word
    // in the same cycle the last serial bit arrives.
    assign o_pnext = sr_d;

endmodule

// File: rtl/serv_rf_word_port.sv
// rtl/serv_rf_word_port.sv - word-parallel host port onto the bit-serial SERV register-file RAM interface
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_*, o_cmd_ready         host command: two reads and/or two writes of 32-bit words
//   o_rsp_valid, o_rsp_rdata0/1  one-cycle read response; data held until the next read response
//   o_rf_rreq, o_rf_wreq         RF read request pulse / write-only request held until grant
//   i_rf_ready                   RF grant
//   o_rf_rreg0/1, o_rf_wreg0/1   register indices, stable from request to end of transfer
//   o_rf_wen0/1                  write enables, stable from request to end of transfer
//   o_rf_wdata0/1, i_rf_rdata0/1 serial data, one bit per cycle, LSB first
module serv_rf_word_port
    import serv_rf_pkg::*;
#(
    parameter  int csr_regs = 4,
    localparam int REGW     = $clog2(32 + csr_regs)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_rd,
    input  logic [REGW-1:0] i_cmd_rreg0,
    input  logic [REGW-1:0] i_cmd_rreg1,
    input  logic            i_cmd_wen0,
    input  logic            i_cmd_wen1,
    input  logic [REGW-1:0] i_cmd_wreg0,
    input  logic [REGW-1:0] i_cmd_wreg1,
    input  logic [31:0]     i_cmd_wdata0,
    input  logic [31:0]     i_cmd_wdata1,
    output logic            o_rsp_valid,
    output logic [31:0]     o_rsp_rdata0,
    output logic [31:0]     o_rsp_rdata1,
    output logic            o_rf_rreq,
    output logic            o_rf_wreq,
    input  logic            i_rf_ready,
    output logic [REGW-1:0] o_rf_rreg0,
    output logic [REGW-1:0] o_rf_rreg1,
    output logic [REGW-1:0] o_rf_wreg0,
    output logic [REGW-1:0] o_rf_wreg1,
    output logic            o_rf_wen0,
    output logic            o_rf_wen1,
    output logic            o_rf_wdata0,
    output logic            o_rf_wdata1,
    input  logic            i_rf_rdata0,
    input  logic            i_rf_rdata1
);

    state_e          state_q,      state_d;
    logic [4:0]      cnt_q,        cnt_d;
    logic [1:0]      rcnt_q,       rcnt_d;
    logic            cmd_ready_q,  cmd_ready_d;
    logic            rreq_q,       rreq_d;
    logic            wreq_q,       wreq_d;
    logic            rsp_valid_q,  rsp_valid_d;
    logic [31:0]     rsp_rdata0_q, rsp_rdata0_d;
    logic [31:0]     rsp_rdata1_q, rsp_rdata1_d;
    logic            rd_q,         rd_d;
    logic            wen0_q,       wen0_d;
    logic            wen1_q,       wen1_d;
    logic [REGW-1:0] rreg0_q,      rreg0_d;
    logic [REGW-1:0] rreg1_q,      rreg1_d;
    logic [REGW-1:0] wreg0_q,      wreg0_d;
    logic [REGW-1:0] wreg1_q,      wreg1_d;

    logic        cmd_go;
    logic        xfer;
    logic        w0_sdata,  w1_sdata;
    logic [31:0] r0_pnext,  r1_pnext;
    logic [31:0] w0_pnext_unused, w1_pnext_unused;
    logic        r0_sdata_unused, r1_sdata_unused;

    // A command with nothing to do is accepted but never leaves IDLE.
    assign cmd_go = i_cmd_valid & cmd_ready_q & (i_cmd_rd | i_cmd_wen0 | i_cmd_wen1);
    assign xfer   = (state_q == ST_XFER);

    // Write words are loaded straight from the command so no separate latch is needed.
    serv_rf_ser32 u_wdata0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (cmd_go),
        .i_pdata (i_cmd_wdata0),
        .i_shift (xfer),
        .i_sdata (1'b0),
        .o_sdata (w0_sdata),
        .o_pnext (w0_pnext_unused)
    );

    serv_rf_ser32 u_wdata1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (cmd_go),
        .i_pdata (i_cmd_wdata1),
        .i_shift (xfer),
        .i_sdata (1'b0),
        .o_sdata (w1_sdata),
        .o_pnext (w1_pnext_unused)
    );

    serv_rf_ser32 u_rdata0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (1'b0),
        .i_pdata (32'd0),
        .i_shift (xfer),
        .i_sdata (i_rf_rdata0),
        .o_sdata (r0_sdata_unused),
        .o_pnext (r0_pnext)
    );

    serv_rf_ser32 u_rdata1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (1'b0),
        .i_pdata (32'd0),
        .i_shift (xfer),
        .i_sdata (i_rf_rdata1),
        .o_sdata (r1_sdata_unused),
        .o_pnext (r1_pnext)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rcnt_d       = rcnt_q;
        rreq_d       = 1'b0;
        wreq_d       = wreq_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata0_d = rsp_rdata0_q;
        rsp_rdata1_d = rsp_rdata1_q;
        rd_d         = rd_q;
        wen0_d       = wen0_q;
        wen1_d       = wen1_q;
        rreg0_d      = rreg0_q;
        rreg1_d      = rreg1_q;
        wreg0_d      = wreg0_q;
        wreg1_d      = wreg1_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_go) begin
                    state_d = ST_REQ;
                    rd_d    = i_cmd_rd;
                    wen0_d  = i_cmd_wen0;
                    wen1_d  = i_cmd_wen1;
                    rreg0_d = i_cmd_rreg0;
                    rreg1_d = i_cmd_rreg1;
                    wreg0_d = i_cmd_wreg0;
                    wreg1_d = i_cmd_wreg1;
                    // Reads (with or without writes) use the pulsed read request;
                    // only a pure write uses the held write request.
                    rreq_d  = i_cmd_rd;
                    wreq_d  = ~i_cmd_rd;
                end
            end
            ST_REQ: begin
                if (i_rf_ready) begin
                    state_d = ST_XFER;
                    wreq_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == XFER_LAST) begin
                    state_d = ST_RECOV;
                    rcnt_d  = '0;
                    wen0_d  = 1'b0;
                    wen1_d  = 1'b0;
                    if (rd_q) begin
                        rsp_valid_d  = 1'b1;
                        rsp_rdata0_d = r0_pnext;
                        rsp_rdata1_d = r1_pnext;
                    end
                end
            end
            ST_RECOV: begin
                rcnt_d = rcnt_q + 2'd1;
                if (rcnt_q == RECOV_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready: low for the first cycle after reset, high whenever
        // the next cycle is IDLE.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            cmd_ready_q  <= 1'b0;
            rreq_q       <= 1'b0;
            wreq_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata0_q <= '0;
            rsp_rdata1_q <= '0;
            rd_q         <= 1'b0;
            wen0_q       <= 1'b0;
            wen1_q       <= 1'b0;
            rreg0_q      <= '0;
            rreg1_q      <= '0;
            wreg0_q      <= '0;
            wreg1_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rreq_q       <= rreq_d;
            wreq_q       <= wreq_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata0_q <= rsp_rdata0_d;
            rsp_rdata1_q <= rsp_rdata1_d;
            rd_q         <= rd_d;
            wen0_q       <= wen0_d;
            wen1_q       <= wen1_d;
            rreg0_q      <= rreg0_d;
            rreg1_q      <= rreg1_d;
            wreg0_q      <= wreg0_d;
            wreg1_q      <= wreg1_d;
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_rdata0 = rsp_rdata0_q;
    assign o_rsp_rdata1 = rsp_rdata1_q;
    assign o_rf_rreq    = rreq_q;
    assign o_rf_wreq    = wreq_q;
    assign o_rf_rreg0   = rreg0_q;
    assign o_rf_rreg1   = rreg1_q;
    assign o_rf_wreg0   = wreg0_q;
    assign o_rf_wreg1   = wreg1_q;
    assign o_rf_wen0    = wen0_q;
    assign o_rf_wen1    = wen1_q;
    // The shift registers keep their contents between commands; only the
    // transfer window may put them on the wire.
    assign o_rf_wdata0  = xfer & w0_sdata;
    assign o_rf_wdata1  = xfer & w1_sdata;

endmodule
